// File: rtl/twf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : twf_pkg
//  Description : Shared types and width helpers for the twiddle-factor
//                address sequencer (state enum, counter width functions).
//  Revision    : 1.0  initial release
// ============================================================================
package twf_pkg;

   // Sequencer states: waiting for a request, or emitting a burst
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } twf_state_e;

   // Width of the beat counter; never narrower than one bit
   function automatic int cnt_w(input int group_size);
      return (group_size <= 1) ? 1 : $clog2(group_size);
   endfunction

   // Width of the group counter; never narrower than one bit
   function automatic int grp_w(input int num_groups);
      return (num_groups <= 1) ? 1 : $clog2(num_groups);
   endfunction

endpackage : twf_pkg
`default_nettype wire

// File: rtl/twf_base_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : twf_base_cnt
//  Description : Group base / group index tracker for the twiddle address
//                sequencer. Advances by OFFSET per completed burst, wraps to
//                zero after NUM_GROUPS groups and pulses o_frame_done.
//  Revision    : 1.0  initial release
// ============================================================================
module twf_base_cnt
   import twf_pkg::*;
#(
   parameter int ADDR_W     = 9,
   parameter int OFFSET     = 128,
   parameter int NUM_GROUPS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_adv,
   input  logic              i_clr,
   output logic [ADDR_W-1:0] o_base,
   output logic [ADDR_W-1:0] o_base_nxt,
   output logic              o_frame_done
);

   localparam int                 c_grp_w    = grp_w(NUM_GROUPS);
   localparam logic [ADDR_W-1:0]  c_offset   = ADDR_W'(OFFSET);
   localparam logic [c_grp_w-1:0] c_grp_last = c_grp_w'(NUM_GROUPS - 1);

   logic [ADDR_W-1:0]  r_base;
   logic [c_grp_w-1:0] r_grp;
   logic               r_frame_done;
   logic               w_grp_last;

   assign w_grp_last   = (r_grp == c_grp_last);
   // Base the next burst will use once the current one completes
   assign o_base_nxt   = w_grp_last ? '0 : (r_base + c_offset);
   assign o_base       = r_base;
   assign o_frame_done = r_frame_done;

   // Step base/group on each completed burst; frame pulse on group wrap
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_base       <= '0;
         r_grp        <= '0;
         r_frame_done <= 1'b0;
      end else if (i_adv) begin
         r_base       <= o_base_nxt;
         r_grp        <= w_grp_last ? '0 : (r_grp + c_grp_w'(1));
         r_frame_done <= w_grp_last;
      end else begin
         r_frame_done <= 1'b0;
      end
   end

endmodule : twf_base_cnt
`default_nettype wire

// File: rtl/twf_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : twf_addr_seq
//  Description : Twiddle-factor ROM address sequencer for the FFT butterfly
//                multiply stage. One burst of GROUP_SIZE addresses per
//                request, with stall, one-deep request queue, back-to-back
//                bursts, frame tracking, clear and overflow flag.
//                Optional macro TWF_IFFT_EN adds inv/twf_conj ports that
//                carry a per-burst conjugate flag alongside the beats.
//  Revision    : 1.0  initial release
// ============================================================================
module twf_addr_seq
   import twf_pkg::*;
#(
   parameter int ADDR_W     = 9,
   parameter int GROUP_SIZE = 4,
   parameter int DATA_NUM   = 16,
   parameter int OFFSET     = 128,
   parameter int NUM_GROUPS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bf_en,
   input  logic              hold,
   input  logic              clear,
   output logic [ADDR_W-1:0] addr,
   output logic              mul_en,
   output logic              alert_CBFP,
   output logic              busy,
   output logic              frame_done,
   output logic              err_ovf
`ifdef TWF_IFFT_EN
   ,
   input  logic              inv,
   output logic              twf_conj
`endif
);

   localparam int                 c_cnt_w    = cnt_w(GROUP_SIZE);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(GROUP_SIZE - 1);
   localparam logic [ADDR_W-1:0]  c_stride   = ADDR_W'(DATA_NUM);

   twf_state_e          r_state, w_state_nxt;
   logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic                r_first, w_first_nxt;
   logic                r_pend, w_pend_nxt;
   logic                r_mul_en, w_mul_en_nxt;
   logic                r_alert, w_alert_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_err_ovf, w_err_ovf_nxt;

   logic [ADDR_W-1:0]   w_base, w_base_nxt;
   logic                w_last, w_start, w_adv;

   // Final beat of the burst is being delivered this cycle
   assign w_last  = (r_state == BURST) && r_mul_en && (r_cnt == c_cnt_last);
   // A burst begins at the next edge (fresh request or chained request)
   assign w_start = !clear && (((r_state == IDLE) && bf_en) ||
                               (w_last && (r_pend || bf_en)));
   assign w_adv   = w_last && !clear;

   twf_base_cnt #(
      .ADDR_W     (ADDR_W),
      .OFFSET     (OFFSET),
      .NUM_GROUPS (NUM_GROUPS)
   ) u_base_cnt (
      .clk          (clk),
      .rst          (rst),
      .i_adv        (w_adv),
      .i_clr        (clear),
      .o_base       (w_base),
      .o_base_nxt   (w_base_nxt),
      .o_frame_done (frame_done)
   );

   // Next-state and next-output decode; beats are gated by hold one cycle late
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_addr_nxt    = r_addr;
      w_first_nxt   = r_first;
      w_pend_nxt    = r_pend;
      w_mul_en_nxt  = 1'b0;
      w_alert_nxt   = 1'b0;
      w_err_ovf_nxt = r_err_ovf;

      if (clear) begin
         w_state_nxt   = IDLE;
         w_cnt_nxt     = '0;
         w_addr_nxt    = '0;
         w_first_nxt   = 1'b0;
         w_pend_nxt    = 1'b0;
         w_err_ovf_nxt = 1'b0;
      end else if (w_start) begin
         // From IDLE the current base is used; when chaining, the base has
         // just advanced so the look-ahead value is the right one.
         w_state_nxt  = BURST;
         w_cnt_nxt    = '0;
         w_addr_nxt   = (r_state == IDLE) ? w_base : w_base_nxt;
         w_first_nxt  = 1'b1;
         w_pend_nxt   = 1'b0;
         w_mul_en_nxt = ~hold;
         w_alert_nxt  = ~hold;
      end else if (w_last) begin
         w_state_nxt  = IDLE;
         w_cnt_nxt    = '0;
         w_addr_nxt   = w_base_nxt;
         w_first_nxt  = 1'b0;
      end else if (r_state == BURST) begin
         if (r_mul_en) begin
            w_cnt_nxt    = r_cnt + c_cnt_w'(1);
            w_addr_nxt   = r_addr + c_stride;
            w_first_nxt  = 1'b0;
            w_mul_en_nxt = ~hold;
         end else begin
            w_mul_en_nxt = ~hold;
            w_alert_nxt  = ~hold & r_first;
         end
         if (bf_en) begin
            if (r_pend) begin
               w_err_ovf_nxt = 1'b1;
            end else begin
               w_pend_nxt = 1'b1;
            end
         end
      end

      w_busy_nxt = (w_state_nxt == BURST) || w_pend_nxt;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_first   <= 1'b0;
         r_pend    <= 1'b0;
         r_mul_en  <= 1'b0;
         r_alert   <= 1'b0;
         r_busy    <= 1'b0;
         r_err_ovf <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_addr    <= w_addr_nxt;
         r_first   <= w_first_nxt;
         r_pend    <= w_pend_nxt;
         r_mul_en  <= w_mul_en_nxt;
         r_alert   <= w_alert_nxt;
         r_busy    <= w_busy_nxt;
         r_err_ovf <= w_err_ovf_nxt;
      end
   end

   assign addr       = r_addr;
   assign mul_en     = r_mul_en;
   assign alert_CBFP = r_alert;
   assign busy       = r_busy;
   assign err_ovf    = r_err_ovf;

`ifdef TWF_IFFT_EN
   logic r_inv;
   logic r_twf_conj;

   // Capture inv at burst start and present it for the life of that burst
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inv      <= 1'b0;
         r_twf_conj <= 1'b0;
      end else begin
         if (w_start) begin
            r_inv <= inv;
         end
         r_twf_conj <= (w_state_nxt == BURST) && (w_start ? inv : r_inv);
      end
   end

   assign twf_conj = r_twf_conj;
`endif

endmodule : twf_addr_seq
`default_nettype wire

// File: doc/twf_addr_seq.md
# twf_addr_seq

Parametrised twiddle-factor address sequencer for the FFT butterfly-multiply stage. Each `bf_en` request produces one burst of `GROUP_SIZE` twiddle ROM addresses with a matching `mul_en` beat strobe and a first-beat `alert_CBFP` marker. It walks `NUM_GROUPS` group bases per frame, then wraps. Compared with the single-mode controller it adds back-pressure (`hold`), a one-deep request queue, back-to-back bursts, frame tracking, synchronous clear and overflow reporting.

## Interface
- `ADDR_W`, 9, twiddle ROM address width.
- `GROUP_SIZE`, 4, beats per burst; must be ≥1.
- `DATA_NUM`, 16, address stride between beats within a burst.
- `OFFSET`, 128, base stride between consecutive groups.
- `NUM_GROUPS`, 4, groups per frame; must be ≥1.
- `clk`  in  1  clock; one clock domain only.
- `rst`  in  1  reset; synchronous, active-high.
- `bf_en`  in  1  burst request, sampled every cycle.
- `hold`  in  1  stall; sampled, takes effect on the next cycle's beat.
- `clear`  in  1  synchronous frame restart.
- `addr`  out  ADDR_W  twiddle ROM address, registered.
- `mul_en`  out  1  beat valid, registered.
- `alert_CBFP`  out  1  high only on the first delivered beat of a burst.
- `busy`  out  1  burst active or request pending.
- `frame_done`  out  1  one-cycle pulse after the last beat of group `NUM_GROUPS-1`.
- `err_ovf`  out  1  sticky; a request was dropped.

## Operation
- States: IDLE and BURST.
- Registers:
  - `base`: current group base.
  - `grp`: 0..NUM_GROUPS-1.
  - `cnt`: beats delivered, 0..GROUP_SIZE-1.
  - `pend`: one-deep request flag.
  - `first`: first beat not yet delivered.
- IDLE:
  - `bf_en`=1 → BURST, `first`=1, `cnt`=0, `addr`=`base`.
  - `mul_en` next = ~`hold`.
- BURST: a beat is delivered on any cycle with `mul_en`=1.
  - On delivery: `cnt`+1, `addr`+`DATA_NUM`, `first`←0.
  - Next `mul_en` = beats remaining & ~`hold`.
  - While `mul_en`=0, `addr` and `cnt` hold.
- `alert_CBFP` = `mul_en` & `first`, registered with `mul_en`.
- End of burst, on delivery of beat `cnt`=GROUP_SIZE-1:
  - `base` ← `base`+`OFFSET`, `grp`+1.
  - If `grp`=NUM_GROUPS-1: `base`←0, `grp`←0, `frame_done` pulses next cycle.
  - If `pend` or `bf_en` is high in that cycle, start the next burst immediately: no idle gap, `addr`=new base, `first`=1, `pend` cleared.
  - Otherwise → IDLE, `addr`=new base, `mul_en`=0.
- `bf_en` in BURST outside the last-beat cycle:
  - `pend`←1.
  - If `pend` is already set, drop the request and set `err_ovf`.
- All address arithmetic is unsigned modulo 2^ADDR_W; overflow wraps silently.
- `clear`:
  - → IDLE; `base`, `grp`, `cnt`, `pend`, `addr`, `mul_en`, `alert_CBFP` all go to 0.
  - `err_ovf` also clears.
  - `bf_en` in the same cycle is ignored.
  - `rst` has priority over `clear`.
- `busy` = (state==BURST) | `pend`, registered.

## Timing
- Reset values: all outputs 0; state IDLE; `base`=0.
- Latency: `bf_en` in cycle t → first beat (`mul_en`=1, `alert_CBFP`=1, `addr`=base) in t+1.
- Unstalled burst: beats t+1..t+GROUP_SIZE. Next base appears on `addr` at t+GROUP_SIZE+1.
- `hold` sampled at edge t suppresses the beat at t+1. Each held cycle extends the burst by one cycle.
- If `hold` covers the first beat, `alert_CBFP` moves to the first beat actually delivered.
- Back-to-back bursts: beat GROUP_SIZE of burst n is followed by beat 1 of burst n+1 in the next cycle.
- `frame_done` is asserted in the cycle after the final beat, coincident with `addr`=0. In a back-to-back case it coincides with the new burst's first beat.
- `rst` or `clear` mid-burst: outputs return to 0 in the next cycle; no partial-burst state survives.

## Configuration
- `TWF_IFFT_EN` defined:
  - Adds input `inv` (1 bit) and output `twf_conj` (1 bit, reset 0).
  - `inv` is latched at burst start and driven on `twf_conj` for every beat of that burst.
  - `twf_conj` is 0 outside bursts.
  - Addresses are unchanged; the multiplier conjugates.
- Not defined: both ports are absent and behaviour is otherwise identical.

## Structure
- Package `twf_pkg` holds:
  - the state enum (IDLE, BURST);
  - a `cnt_w(GROUP_SIZE)` width function (`$clog2` with a minimum of 1);
  - a `grp_w(NUM_GROUPS)` width function, same rule.
- Sub-module `twf_base_cnt` owns the `base`/`grp` registers and `frame_done`. Its inputs are advance and clear. The top level owns the FSM, `cnt`, `pend` and the outputs.

## Test plan
- Single request, defaults, `hold`=0: `addr` = 0,16,32,48 on 4 consecutive beats; `alert_CBFP` on beat 1 only; `addr`=128 afterwards; `busy` deasserts.
- Four requests spaced out: bases 0,128,256,384, then wrap to 0. `frame_done` pulses once, in the cycle after beat 48+384=432.
- `bf_en` during beat 2, then again in the last-beat cycle: bursts run back-to-back, eight contiguous `mul_en` cycles, `err_ovf`=0.
- Three `bf_en` inside one burst: second is queued, third is dropped, `err_ovf`=1 sticky; exactly two bursts are produced.
- `hold`=1 for the 2 cycles after the request: `mul_en` stays low 2 cycles, then 0,16,32,48; `alert_CBFP` lands on `addr`=0.
- `clear` at beat 3 of group 2: next cycle `mul_en`=0 and `addr`=0; a fresh request restarts from base 0. With `TWF_IFFT_EN` and `inv`=1 at the request, `twf_conj`=1 for all 4 beats.
